// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: frames PS/2 stream bytes into 3-byte packets, validates them,
// integrates the deltas into a clamped cursor and hands out frozen new/old positions.
module mouse_packet_decoder #(
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int DELTA_SHIFT = 0,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic           iClk,
   input  logic           iResetn,
   input  logic [7:0]     iByte,
   input  logic           iByteValid,
   input  logic           iEnable,
   input  logic           iMoveAck,
   output logic           oBtnL,
   output logic           oBtnR,
   output logic           oMove,
   output logic [X_W-1:0] oNewX,
   output logic [Y_W-1:0] oNewY,
   output logic [X_W-1:0] oOldX,
   output logic [Y_W-1:0] oOldY,
   output logic           oPktErr
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [X_W-1:0] X_MID = X_W'(SCREEN_W / 2);
   localparam logic [Y_W-1:0] Y_MID = Y_W'(SCREEN_H / 2);

   typedef enum logic [1:0] {B0, B1, B2, COMMIT} state_t;

   state_t         state_q, state_d;
   // status keeps only {y_ovf, x_ovf, y_sign, x_sign, btn_r, btn_l}
   logic [5:0]     status_q, status_d;
   logic [7:0]     dx_q, dx_d, dy_q, dy_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [X_W-1:0] cur_x_q, cur_x_d, new_x_q, new_x_d, old_x_q, old_x_d;
   logic [Y_W-1:0] cur_y_q, cur_y_d, new_y_q, new_y_d, old_y_q, old_y_d;
   logic           btn_l_q, btn_l_d, btn_r_q, btn_r_d, err_q, err_d;
   logic           take, ovf;
   logic signed [8:0] dxs, dys;
   logic [11:0]    x_sum, y_sum;
   logic [X_W-1:0] x_clamp;
   logic [Y_W-1:0] y_clamp;

   always_comb begin
      take    = iByteValid && iEnable;
      ovf     = status_q[5] || status_q[4];
      dxs     = $signed({status_q[2], dx_q}) >>> DELTA_SHIFT;
      dys     = $signed({status_q[3], dy_q}) >>> DELTA_SHIFT;
      x_sum   = 12'(cur_x_q) + {{3{dxs[8]}}, dxs};
      // PS/2 reports +Y as up, screen Y grows downward
      y_sum   = 12'(cur_y_q) - {{3{dys[8]}}, dys};
      x_clamp = x_sum[11] ? '0 : (x_sum > 12'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : x_sum[X_W-1:0];
      y_clamp = y_sum[11] ? '0 : (y_sum > 12'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : y_sum[Y_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      tmo_d    = '0;
      err_d    = 1'b0;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      btn_l_d  = btn_l_q;
      btn_r_d  = btn_r_q;
      new_x_d  = iMoveAck ? cur_x_q : new_x_q;
      new_y_d  = iMoveAck ? cur_y_q : new_y_q;
      old_x_d  = iMoveAck ? new_x_q : old_x_q;
      old_y_d  = iMoveAck ? new_y_q : old_y_q;
      unique case (state_q)
         B0: begin
            if (take && iByte != 8'hFA) begin
               if (!iByte[3]) err_d = 1'b1;
               else begin
                  status_d = {iByte[7:4], iByte[1:0]};
                  state_d  = B1;
               end
            end
         end
         B1, B2: begin
            if (!iEnable) state_d = B0;
            else if (take) begin
               dx_d    = (state_q == B1) ? iByte : dx_q;
               dy_d    = (state_q == B2) ? iByte : dy_q;
               state_d = (state_q == B1) ? B2 : COMMIT;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = B0;
               err_d   = 1'b1;
            end else tmo_d = tmo_q + 1'b1;
         end
         COMMIT: begin
            state_d = B0;
            err_d   = take || ovf;
            if (!ovf) begin
               cur_x_d = x_clamp;
               cur_y_d = y_clamp;
               btn_l_d = status_q[0];
               btn_r_d = status_q[1];
            end
         end
         default: state_d = B0;
      endcase
   end

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         state_q  <= B0;
         status_q <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         tmo_q    <= '0;
         cur_x_q  <= X_MID;
         cur_y_q  <= Y_MID;
         new_x_q  <= X_MID;
         new_y_q  <= Y_MID;
         old_x_q  <= X_MID;
         old_y_q  <= Y_MID;
         btn_l_q  <= 1'b0;
         btn_r_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         tmo_q    <= tmo_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         new_x_q  <= new_x_d;
         new_y_q  <= new_y_d;
         old_x_q  <= old_x_d;
         old_y_q  <= old_y_d;
         btn_l_q  <= btn_l_d;
         btn_r_q  <= btn_r_d;
         err_q    <= err_d;
      end
   end

   assign oBtnL   = btn_l_q;
   assign oBtnR   = btn_r_q;
   assign oMove   = (cur_x_q != new_x_q) || (cur_y_q != new_y_q);
   assign oNewX   = new_x_q;
   assign oNewY   = new_y_q;
   assign oOldX   = old_x_q;
   assign oOldY   = old_y_q;
   assign oPktErr = err_q;
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// tb_mouse_packet_decoder: table-driven packets with a scoreboard of expected cursor/button
// state, plus hand sequences for timeout, COMMIT collisions, ack/commit overlap and reset.
module tb_mouse_packet_decoder;
   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] iByte = '0;
   logic       iByteValid = 1'b0, iEnable = 1'b1, iMoveAck = 1'b0;
   logic       oBtnL, oBtnR, oMove, oPktErr;
   logic [7:0] oNewX, oOldX;
   logic [6:0] oNewY, oOldY;

   mouse_packet_decoder #(.TIMEOUT_CYC(TO)) dut (
      .iClk(clk), .iResetn(rst_n), .iByte(iByte), .iByteValid(iByteValid),
      .iEnable(iEnable), .iMoveAck(iMoveAck), .oBtnL(oBtnL), .oBtnR(oBtnR),
      .oMove(oMove), .oNewX(oNewX), .oNewY(oNewY), .oOldX(oOldX), .oOldY(oOldY),
      .oPktErr(oPktErr)
   );

   always #5 clk = ~clk;

   typedef struct {int x, y, bl, br, mv, err;} exp_t;
   typedef struct {int nb; logic [7:0] b0, b1, b2, b3; exp_t e;} vec_t;

   exp_t sb[$];
   vec_t tbl[11];
   int checks = 0, failures = 0, err_cnt = 0, err_base = 0, prev_x = 80, prev_y = 60;

   always @(negedge clk) if (oPktErr) err_cnt++;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      @(negedge clk);
      iByte = b;
      iByteValid = 1'b1;
      iMoveAck = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         iByteValid = 1'b0;
         iMoveAck = 1'b0;
      end
   endtask

   task automatic push(input int x, y, bl, br, mv, err);
      exp_t e;
      e = '{x, y, bl, br, mv, err};
      sb.push_back(e);
   endtask

   task automatic check_expect(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, " move"}, int'(oMove), e.mv);
      chk({tag, " err"}, err_cnt - err_base, e.err);
      chk({tag, " btnL"}, int'(oBtnL), e.bl);
      chk({tag, " btnR"}, int'(oBtnR), e.br);
      @(negedge clk);
      iMoveAck = 1'b1;
      @(negedge clk);
      iMoveAck = 1'b0;
      chk({tag, " newX"}, int'(oNewX), e.x);
      chk({tag, " newY"}, int'(oNewY), e.y);
      chk({tag, " oldX"}, int'(oOldX), prev_x);
      chk({tag, " oldY"}, int'(oOldY), prev_y);
      chk({tag, " move after ack"}, int'(oMove), 0);
      prev_x = e.x;
      prev_y = e.y;
      err_base = err_cnt;
   endtask

   initial begin
      tbl[0]  = '{3, 8'h09, 8'h05, 8'h03, 8'h00, '{85, 57, 1, 0, 1, 0}};
      tbl[1]  = '{3, 8'h28, 8'h00, 8'h80, 8'h00, '{85, 119, 0, 0, 1, 0}};
      tbl[2]  = '{3, 8'h08, 8'h00, 8'h7F, 8'h00, '{85, 0, 0, 0, 1, 0}};
      tbl[3]  = '{3, 8'h18, 8'h00, 8'h00, 8'h00, '{0, 0, 0, 0, 1, 0}};
      tbl[4]  = '{3, 8'h08, 8'h7F, 8'h00, 8'h00, '{127, 0, 0, 0, 1, 0}};
      tbl[5]  = '{3, 8'h08, 8'h7F, 8'h00, 8'h00, '{159, 0, 0, 0, 1, 0}};
      tbl[6]  = '{3, 8'h08, 8'h01, 8'h00, 8'h00, '{159, 0, 0, 0, 0, 0}};
      tbl[7]  = '{4, 8'h02, 8'h19, 8'hFF, 8'h00, '{158, 0, 1, 0, 1, 1}};
      tbl[8]  = '{3, 8'h48, 8'hFF, 8'h00, 8'h00, '{158, 0, 1, 0, 0, 1}};
      tbl[9]  = '{4, 8'hFA, 8'h0A, 8'h00, 8'h00, '{158, 0, 0, 1, 0, 0}};
      tbl[10] = '{3, 8'h38, 8'hFE, 8'hFE, 8'h00, '{156, 2, 0, 0, 1, 0}};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset btnL", int'(oBtnL), 0);
      chk("reset btnR", int'(oBtnR), 0);
      chk("reset move", int'(oMove), 0);
      chk("reset newX", int'(oNewX), 80);
      chk("reset newY", int'(oNewY), 60);
      chk("reset oldX", int'(oOldX), 80);
      chk("reset oldY", int'(oOldY), 60);
      chk("reset err", err_cnt, 0);

      for (int i = 0; i < 11; i++) begin
         put(tbl[i].b0); idle(1);
         put(tbl[i].b1); idle(1);
         put(tbl[i].b2); idle(1);
         if (tbl[i].nb == 4) begin put(tbl[i].b3); idle(1); end
         idle(3);
         sb.push_back(tbl[i].e);
         check_expect($sformatf("vec%0d", i));
      end

      put(8'h08); idle(TO - 5); put(8'h01); put(8'h00); idle(4);
      push(157, 2, 0, 0, 1, 0);
      check_expect("no early timeout");

      put(8'h08); put(8'h01); idle(TO + 5);
      put(8'hFA); put(8'h0A); put(8'h02); put(8'h00); idle(4);
      push(159, 2, 0, 1, 1, 1);
      check_expect("timeout resync");

      put(8'h18); put(8'hFF); put(8'h00); put(8'h18); idle(4);
      push(158, 2, 0, 0, 1, 1);
      check_expect("byte in commit");
      put(8'h08); put(8'h01); put(8'h00); idle(4);
      push(159, 2, 0, 0, 1, 0);
      check_expect("after commit drop");

      put(8'h18); put(8'hFE); put(8'h00); idle(4);
      chk("pre-overlap move", int'(oMove), 1);
      put(8'h18); put(8'hFD); put(8'h00);
      @(negedge clk);
      iByteValid = 1'b0;
      iMoveAck = 1'b1;
      idle(2);
      chk("overlap newX", int'(oNewX), 157);
      chk("overlap oldX", int'(oOldX), 159);
      chk("overlap move", int'(oMove), 1);
      prev_x = 157;
      err_base = err_cnt;
      push(154, 2, 0, 0, 1, 0);
      check_expect("after overlap");

      put(8'h09); put(8'h05); idle(1);
      #2 rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      chk("midreset btnL", int'(oBtnL), 0);
      chk("midreset move", int'(oMove), 0);
      chk("midreset newX", int'(oNewX), 80);
      chk("midreset newY", int'(oNewY), 60);
      chk("midreset oldX", int'(oOldX), 80);
      chk("midreset oldY", int'(oOldY), 60);
      chk("midreset err", err_cnt - err_base, 0);
      prev_x = 80;
      prev_y = 60;
      put(8'h09); put(8'h01); put(8'h00); idle(4);
      push(81, 60, 1, 0, 1, 0);
      check_expect("after reset");

      put(8'h08);
      @(negedge clk);
      iEnable = 1'b0;
      iByte = 8'h33;
      idle(2);
      iEnable = 1'b1;
      put(8'h08); put(8'h02); put(8'h00); idle(4);
      push(83, 60, 0, 0, 1, 0);
      check_expect("enable drop");

      chk("scoreboard empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
